// File: rtl/bp_pkg.sv
// Shared types, defaults and helpers for the dynamic branch predictor.
// The optional return-address stack is enabled with BRANCH_PREDICTOR_RAS_EN.
package bp_pkg;

    localparam int         DEF_XLEN         = 32;
    localparam int         DEF_BHT_ENTRIES  = 64;
    localparam logic [1:0] DEF_COUNTER_INIT = 2'b01;
    localparam int         DEF_RAS_DEPTH    = 4;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_ctr_e;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) begin
                res = ctr + 2'd1;
            end
        end else begin
            if (ctr != SNT) begin
                res = ctr - 2'd1;
            end
        end
        return res;
    endfunction

    // x1 (ra) and x5 (t0) are the link registers of the RISC-V calling convention.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push, pop and replace-top, saturating count.
// Instantiated by the predictor only when BRANCH_PREDICTOR_RAS_EN is defined.
module return_addr_stack
    import bp_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_replace,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_do_replace;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_ptr_inc;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(RAS_DEPTH));
    // A replace on an empty stack has no top to overwrite, so it degrades to a push.
    assign w_do_replace = i_replace & ~w_empty;
    assign w_do_push    = (i_push | i_replace) & ~w_do_replace;
    assign w_do_pop     = i_pop & ~w_empty & ~w_do_push & ~w_do_replace;
    assign w_ptr_inc    = r_ptr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_do_push) begin
            r_ptr <= w_ptr_inc;
            if (!w_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_do_pop) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    // Entry storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_do_replace) begin
            r_stack[r_ptr] <= i_data;
        end else if (w_do_push) begin
            r_stack[w_ptr_inc] <= i_data;
        end
    end

    assign o_top   = r_stack[r_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/dynamic_branch_predictor.sv
// ID-stage predictor: BHT of 2-bit counters for B-type, computed JAL/JALR targets.
// Define BRANCH_PREDICTOR_RAS_EN to add a return-address stack for JALR returns.
module dynamic_branch_predictor
    import bp_pkg::*;
#(
    parameter int         XLEN         = DEF_XLEN,
    parameter int         BHT_ENTRIES  = DEF_BHT_ENTRIES,
    parameter logic [1:0] COUNTER_INIT = DEF_COUNTER_INIT,
    parameter int         RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lookup_en_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            is_compressed_i,
    input  logic            branch_btype_i,
    input  logic            branch_jal_i,
    input  logic            branch_jalr_i,
    input  logic [4:0]      rd_idx_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic            rs1_depended_i,
    input  logic            update_en_i,
    input  logic [XLEN-1:0] update_pc_i,
    input  logic            update_taken_i,
    output logic            taken_o,
    output logic [XLEN-1:0] redirection_pc_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];

    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_lkp_ctr;
    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_pc_off;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic             w_sel_jal;
    logic             w_sel_jalr;
    logic             w_sel_b;
    logic             w_ras_pop;
    logic [XLEN-1:0]  w_ras_top;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic             w_unused_bits;

    // Bit 0 is dropped so 16-bit instructions at odd halfwords get their own counter.
    assign w_lkp_idx = pc_i[IDX_W:1];
    assign w_upd_idx = update_pc_i[IDX_W:1];
    assign w_lkp_ctr = r_bht[w_lkp_idx];

    assign w_pc_next  = pc_i + (is_compressed_i ? XLEN'(2) : XLEN'(4));
    assign w_pc_off   = pc_i + offset_i;
    assign w_jalr_sum = rs1_data_i + offset_i;
    assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};

    assign w_sel_jal  = branch_jal_i;
    assign w_sel_jalr = branch_jalr_i & ~branch_jal_i;
    assign w_sel_b    = branch_btype_i & ~branch_jal_i & ~branch_jalr_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= COUNTER_INIT;
            end
        end else if (update_en_i) begin
            r_bht[w_upd_idx] <= sat_update(r_bht[w_upd_idx], update_taken_i);
        end
    end

`ifdef BRANCH_PREDICTOR_RAS_EN
    logic w_rd_link;
    logic w_rs1_link;
    logic w_ras_push;
    logic w_ras_replace;
    logic w_ras_empty;
    logic w_ras_full;

    assign w_rd_link     = is_link_reg(rd_idx_i);
    assign w_rs1_link    = is_link_reg(rs1_idx_i);
    assign w_ras_pop     = lookup_en_i & w_sel_jalr & w_rs1_link & ~w_rd_link & ~w_ras_empty;
    // Co-routine swap: the caller's return replaces the callee's, so depth is unchanged.
    assign w_ras_replace = lookup_en_i & w_sel_jalr & w_rd_link & w_rs1_link
                         & (rd_idx_i != rs1_idx_i);
    assign w_ras_push    = lookup_en_i & ~w_ras_replace
                         & ((w_sel_jal & w_rd_link) | (w_sel_jalr & w_rd_link & ~w_ras_pop));

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_ras_push),
        .i_pop     (w_ras_pop),
        .i_replace (w_ras_replace),
        .i_data    (w_pc_next),
        .o_top     (w_ras_top),
        .o_empty   (w_ras_empty),
        .o_full    (w_ras_full)
    );

    assign w_unused_bits = ^{update_pc_i, w_ras_full};
`else
    assign w_ras_pop     = 1'b0;
    assign w_ras_top     = '0;
    assign w_unused_bits = ^{update_pc_i, lookup_en_i, rd_idx_i, rs1_idx_i, 32'(RAS_DEPTH)};
`endif

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc_next;
        if (w_sel_jal) begin
            w_taken  = 1'b1;
            w_target = w_pc_off;
        end else if (w_sel_jalr) begin
            if (w_ras_pop) begin
                w_taken  = 1'b1;
                w_target = w_ras_top;
            end else if (!rs1_depended_i) begin
                w_taken  = 1'b1;
                w_target = w_jalr_tgt;
            end
        end else if (w_sel_b && w_lkp_ctr[1]) begin
            w_taken  = 1'b1;
            w_target = w_pc_off;
        end
    end

    assign taken_o          = w_taken;
    assign redirection_pc_o = w_target;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Scoreboard bench for dynamic_branch_predictor: directed vectors queue expectations,
// a negedge monitor pops and compares. RAS vectors depend on BRANCH_PREDICTOR_RAS_EN.
module tb_dynamic_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_en_i;
    logic [31:0] pc_i;
    logic        is_compressed_i;
    logic        branch_btype_i;
    logic        branch_jal_i;
    logic        branch_jalr_i;
    logic [4:0]  rd_idx_i;
    logic [4:0]  rs1_idx_i;
    logic [31:0] rs1_data_i;
    logic [31:0] offset_i;
    logic        rs1_depended_i;
    logic        update_en_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        taken_o;
    logic [31:0] redirection_pc_o;

    dynamic_branch_predictor #(
        .XLEN         (32),
        .BHT_ENTRIES  (64),
        .COUNTER_INIT (2'b01),
        .RAS_DEPTH    (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_en_i      (lookup_en_i),
        .pc_i             (pc_i),
        .is_compressed_i  (is_compressed_i),
        .branch_btype_i   (branch_btype_i),
        .branch_jal_i     (branch_jal_i),
        .branch_jalr_i    (branch_jalr_i),
        .rd_idx_i         (rd_idx_i),
        .rs1_idx_i        (rs1_idx_i),
        .rs1_data_i       (rs1_data_i),
        .offset_i         (offset_i),
        .rs1_depended_i   (rs1_depended_i),
        .update_en_i      (update_en_i),
        .update_pc_i      (update_pc_i),
        .update_taken_i   (update_taken_i),
        .taken_o          (taken_o),
        .redirection_pc_o (redirection_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    logic chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [31:0] BPC  = 32'h8000_0010;
    localparam logic [31:0] BOFF = 32'hFFFF_FFF0;

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor: output presented with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (taken_o !== e.taken || redirection_pc_o !== e.pc) begin
                    n_fail++;
                    $display("FAIL %s: got taken=%0b pc=%h, expected taken=%0b pc=%h",
                             e.nm, taken_o, redirection_pc_o, e.taken, e.pc);
                end
            end
        end
    end

    task automatic clr();
        lookup_en_i = 1'b0; pc_i = '0; is_compressed_i = 1'b0;
        branch_btype_i = 1'b0; branch_jal_i = 1'b0; branch_jalr_i = 1'b0;
        rd_idx_i = '0; rs1_idx_i = '0; rs1_data_i = '0; offset_i = '0;
        rs1_depended_i = 1'b0;
    endtask

    task automatic set_b(input logic [31:0] pc, input logic [31:0] off, input logic comp);
        clr();
        branch_btype_i = 1'b1; pc_i = pc; offset_i = off; is_compressed_i = comp;
    endtask

    task automatic set_jal(input logic [31:0] pc, input logic [31:0] off,
                           input logic [4:0] rd, input logic en);
        clr();
        branch_jal_i = 1'b1; pc_i = pc; offset_i = off; rd_idx_i = rd; lookup_en_i = en;
    endtask

    task automatic set_jalr(input logic [31:0] pc, input logic comp, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [31:0] rs1d,
                            input logic [31:0] off, input logic dep, input logic en);
        clr();
        branch_jalr_i = 1'b1; pc_i = pc; is_compressed_i = comp; rd_idx_i = rd;
        rs1_idx_i = rs1; rs1_data_i = rs1d; offset_i = off; rs1_depended_i = dep;
        lookup_en_i = en;
    endtask

    // Queue the expected response for the current inputs, then advance one cycle.
    task automatic expect_out(input logic t, input logic [31:0] p, input string nm);
        exp_t e;
        e.taken = t; e.pc = p; e.nm = nm;
        exp_q.push_back(e);
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        update_en_i = 1'b0;
    endtask

    task automatic upd(input logic [31:0] p, input logic t, input int n);
        for (int i = 0; i < n; i++) begin
            update_en_i = 1'b1; update_pc_i = p; update_taken_i = t;
            @(posedge clk); #1;
        end
        update_en_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr();
        update_en_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0;
        @(posedge clk); #1;
        expect_out(1'b0, 32'h0000_0004, "reset_state");
        reset = 1'b0;

        // Training
        set_b(BPC, BOFF, 1'b0);
        expect_out(1'b0, 32'h8000_0014, "init_not_taken");
        upd(BPC, 1'b1, 2);
        expect_out(1'b1, 32'h8000_0000, "trained_taken");
        upd(BPC, 1'b0, 2);
        expect_out(1'b0, 32'h8000_0014, "trained_back_nt");

        // Saturation
        upd(BPC, 1'b1, 5);
        upd(BPC, 1'b0, 1);
        expect_out(1'b1, 32'h8000_0000, "sat_high_then_nt");
        upd(BPC, 1'b0, 5);
        upd(BPC, 1'b1, 1);
        expect_out(1'b0, 32'h8000_0014, "sat_low_then_t");

        // Same-cycle lookup and update at the same index
        update_en_i = 1'b1; update_pc_i = BPC; update_taken_i = 1'b1;
        expect_out(1'b0, 32'h8000_0014, "collision_old_value");
        expect_out(1'b1, 32'h8000_0000, "collision_next_cycle");

        // Neighbouring index untouched; aliased PC shares index 8
        set_b(32'h8000_0012, BOFF, 1'b1);
        expect_out(1'b0, 32'h8000_0014, "other_index_init");
        set_b(32'h8000_0090, 32'h0000_0020, 1'b0);
        expect_out(1'b1, 32'h8000_00B0, "aliased_index");

        // Reset mid-run, asserted between clock edges
        upd(BPC, 1'b1, 1);
        set_b(BPC, BOFF, 1'b0);
        #2 reset = 1'b1;
        expect_out(1'b0, 32'h8000_0014, "reset_midrun");
        reset = 1'b0;
        expect_out(1'b0, 32'h8000_0014, "after_reset");
        upd(BPC, 1'b1, 1);
        expect_out(1'b1, 32'h8000_0000, "init_plus_one");

        // JAL / JALR and flag priority
        set_jal(32'h8000_0100, 32'h0000_0040, 5'd0, 1'b0);
        expect_out(1'b1, 32'h8000_0140, "jal_target");
        set_jal(32'hFFFF_FFF0, 32'h0000_0020, 5'd0, 1'b0);
        expect_out(1'b1, 32'h0000_0010, "jal_wrap");
        set_jal(32'h8000_0100, 32'h0000_0040, 5'd0, 1'b0);
        branch_jalr_i = 1'b1; branch_btype_i = 1'b1; rs1_depended_i = 1'b1;
        expect_out(1'b1, 32'h8000_0140, "prio_jal");
        set_jalr(32'h8000_0100, 1'b0, 5'd0, 5'd2, 32'h8000_0300, 32'h0000_0004, 1'b0, 1'b0);
        branch_btype_i = 1'b1;
        expect_out(1'b1, 32'h8000_0304, "prio_jalr_over_b");
        set_jalr(32'h8000_0100, 1'b1, 5'd0, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0);
        expect_out(1'b0, 32'h8000_0102, "jalr_hazard");
        set_jalr(32'h8000_0100, 1'b0, 5'd0, 5'd2, 32'h8000_0201, 32'h0, 1'b0, 1'b0);
        expect_out(1'b1, 32'h8000_0200, "jalr_lsb_clear");
        set_jalr(32'h8000_0100, 1'b0, 5'd0, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expect_out(1'b1, 32'h7FFF_FFFE, "jalr_neg_offset");
        clr();
        pc_i = 32'hFFFF_FFFE;
        expect_out(1'b0, 32'h0000_0002, "no_branch_wrap");

`ifdef BRANCH_PREDICTOR_RAS_EN
        set_jal(32'h8000_0000, 32'h0000_0100, 5'd1, 1'b1);
        expect_out(1'b1, 32'h8000_0100, "ras_call");
        set_jalr(32'h8000_0100, 1'b0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b1, 1'b1);
        expect_out(1'b1, 32'h8000_0004, "ras_return");
        set_jalr(32'h8000_0104, 1'b0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b1, 1'b1);
        expect_out(1'b0, 32'h8000_0108, "ras_empty_fallback");
        set_jal(32'h8000_0200, 32'h0000_0040, 5'd1, 1'b1);
        expect_out(1'b1, 32'h8000_0240, "ras_call2");
        set_jalr(32'h8000_0240, 1'b1, 5'd5, 5'd1, 32'h8000_0401, 32'h0, 1'b0, 1'b1);
        expect_out(1'b1, 32'h8000_0400, "ras_swap_rs1_path");
        set_jalr(32'h8000_0300, 1'b0, 5'd0, 5'd5, 32'h0, 32'h0, 1'b1, 1'b1);
        expect_out(1'b1, 32'h8000_0242, "ras_replaced_top");
        set_jalr(32'h8000_0304, 1'b0, 5'd0, 5'd5, 32'h0, 32'h0, 1'b1, 1'b1);
        expect_out(1'b0, 32'h8000_0308, "ras_count_unchanged");
`else
        set_jal(32'h8000_0000, 32'h0000_0100, 5'd1, 1'b1);
        expect_out(1'b1, 32'h8000_0100, "noras_call");
        set_jalr(32'h8000_0100, 1'b0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b1, 1'b1);
        expect_out(1'b0, 32'h8000_0104, "noras_return_rs1_path");
`endif

        clr();
        repeat (2) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
